// File: rtl/row_sync_engine.sv
// row_sync_engine: responder for row-cache misses. Writes back a dirty victim
// row from the row buffer to backing memory, fills the slot with the requested
// row, then pulses sync. All memory/buffer outputs are decoded from state.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for hold; request fields are latched on capture
// WB      | writing victim row beats from the row buffer to memory
// FILL    | reading target row beats into the row buffer
// DONE    | slot ready, sync pulses for this single cycle
// RELEASE | waiting for the cache to drop hold before accepting again
module row_sync_engine #(
    parameter int CHWIDTH   = 5,
    parameter int ADDRWIDTH = 17,
    parameter int BEATWIDTH = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           hold,
    input  logic [ADDRWIDTH-1:0]           RowId,
    input  logic [CHWIDTH-1:0]             cRowId,
    input  logic                           victimValid,
    input  logic                           victimDirty,
    input  logic [ADDRWIDTH-1:0]           victimRowId,
    output logic                           memReq,
    output logic                           memWr,
    output logic [ADDRWIDTH+BEATWIDTH-1:0] memAddr,
    input  logic                           memAck,
    output logic [CHWIDTH+BEATWIDTH-1:0]   bufAddr,
    output logic                           bufWE,
    output logic                           busy,
    output logic                           sync
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_FILL,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [BEATWIDTH-1:0]   beat;
    logic [ADDRWIDTH-1:0]   row_l;
    logic [ADDRWIDTH-1:0]   vrow_l;
    logic [CHWIDTH-1:0]     slot_l;
    logic                   beat_last;
    logic                   victim_hit;

    assign beat_last  = &beat;
    assign victim_hit = victimValid && (victimRowId == RowId);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request capture and beat counter; the counter only wraps on the final
    // acknowledged beat of a row, which is also the phase change.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat   <= '0;
            row_l  <= '0;
            vrow_l <= '0;
            slot_l <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    beat <= '0;
                    if (hold) begin
                        row_l  <= RowId;
                        vrow_l <= victimRowId;
                        slot_l <= cRowId;
                    end
                end
                S_WB, S_FILL: begin
                    if (memAck) begin
                        beat <= beat + {{(BEATWIDTH-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    beat <= '0;
                end
            endcase
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (hold) begin
                    if (victim_hit) begin
                        state_nxt = S_DONE;
                    end else if (victimValid && victimDirty) begin
                        state_nxt = S_WB;
                    end else begin
                        state_nxt = S_FILL;
                    end
                end
            end
            S_WB: begin
                if (memAck && beat_last) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (memAck && beat_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (!hold) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode; addresses read zero outside the transfer states.
    always_comb begin
        memReq  = 1'b0;
        memWr   = 1'b0;
        memAddr = '0;
        bufAddr = '0;
        bufWE   = 1'b0;
        busy    = (state != S_IDLE);
        sync    = (state == S_DONE);
        case (state)
            S_WB: begin
                memReq  = 1'b1;
                memWr   = 1'b1;
                memAddr = {vrow_l, beat};
                bufAddr = {slot_l, beat};
            end
            S_FILL: begin
                memReq  = 1'b1;
                memAddr = {row_l, beat};
                bufAddr = {slot_l, beat};
                bufWE   = memAck;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_row_sync_engine.sv
// Bench for row_sync_engine: driver pushes expected beats and sync cycles into
// queues, a monitor pops and compares whenever the DUT presents a beat or sync.
module tb_row_sync_engine;

    logic        clk;
    logic        rst;
    logic        hold;
    logic [16:0] RowId;
    logic [4:0]  cRowId;
    logic        victimValid;
    logic        victimDirty;
    logic [16:0] victimRowId;
    logic        memReq;
    logic        memWr;
    logic [19:0] memAddr;
    logic        memAck;
    logic [7:0]  bufAddr;
    logic        bufWE;
    logic        busy;
    logic        sync;

    typedef struct packed {
        logic        wr;
        logic [19:0] addr;
        logic [7:0]  baddr;
    } beat_t;

    beat_t exp_q[$];
    int    sync_q[$];
    int    checks;
    int    failures;
    int    cyc;
    int    sync_count;
    logic  bp;
    int    stall_cnt;
    logic  prev_stall;
    logic [19:0] prev_addr;
    logic        prev_wr;

    row_sync_engine #(.CHWIDTH(5), .ADDRWIDTH(17), .BEATWIDTH(3)) dut (
        .clk(clk), .rst(rst), .hold(hold), .RowId(RowId), .cRowId(cRowId),
        .victimValid(victimValid), .victimDirty(victimDirty),
        .victimRowId(victimRowId), .memReq(memReq), .memWr(memWr),
        .memAddr(memAddr), .memAck(memAck), .bufAddr(bufAddr), .bufWE(bufWE),
        .busy(busy), .sync(sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: always acks, or with bp=1 holds ack low 3 cycles per beat.
    always @(negedge clk) begin
        if (!bp) begin
            memAck = 1'b1;
            stall_cnt = 0;
        end else if (memReq) begin
            if (stall_cnt == 3) begin
                memAck = 1'b1;
                stall_cnt = 0;
            end else begin
                memAck = 1'b0;
                stall_cnt = stall_cnt + 1;
            end
        end else begin
            memAck = 1'b0;
            stall_cnt = 0;
        end
    end

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: compares beats on ack, bufWE every cycle, sync timing, stall stability.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check1("bufWE", {31'd0, bufWE}, {31'd0, memReq && memAck && !memWr});
            if (prev_stall && memReq) begin
                check1("stall_addr", {12'd0, memAddr}, {12'd0, prev_addr});
                check1("stall_wr", {31'd0, memWr}, {31'd0, prev_wr});
            end
            if (memReq && memAck) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=addr %0d required=no beat", memAddr);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check1("beat_wr", {31'd0, memWr}, {31'd0, e.wr});
                    check1("beat_addr", {12'd0, memAddr}, {12'd0, e.addr});
                    check1("beat_buf", {24'd0, bufAddr}, {24'd0, e.baddr});
                end
            end
            if (sync) begin
                sync_count++;
                if (sync_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_sync actual=cycle %0d required=none", cyc + 1);
                end else begin
                    int es;
                    es = sync_q.pop_front();
                    check1("sync_cycle", cyc + 1, es);
                end
            end
            prev_stall = memReq && !memAck;
            prev_addr  = memAddr;
            prev_wr    = memWr;
        end
    end

    // One request: wb_base/rd_base < 0 mean no writeback/fill; lat is the
    // edge (counted from capture) at which sync is sampled high.
    task automatic do_req(input logic [16:0] row, input logic [4:0] slot,
                          input logic vv, input logic vd, input logic [16:0] vrow,
                          input int wb_base, input int rd_base, input int buf_base,
                          input int lat);
        int c;
        int prev;
        if (wb_base >= 0)
            for (int b = 0; b < 8; b++)
                exp_q.push_back('{1'b1, 20'(wb_base + b), 8'(buf_base + b)});
        if (rd_base >= 0)
            for (int b = 0; b < 8; b++)
                exp_q.push_back('{1'b0, 20'(rd_base + b), 8'(buf_base + b)});
        prev = sync_count;
        @(negedge clk);
        hold = 1'b1; RowId = row; cRowId = slot;
        victimValid = vv; victimDirty = vd; victimRowId = vrow;
        @(posedge clk);
        #1;
        c = cyc;
        sync_q.push_back(c + lat);
        RowId = ~row; cRowId = ~slot; victimValid = !vv;
        victimDirty = !vd; victimRowId = ~vrow;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (sync_count != prev) break;
        end
        if (sync_count == prev) begin
            checks++;
            failures++;
            $display("FAIL sync_timeout actual=no sync required=sync at %0d", c + lat);
        end
        repeat (3) begin
            @(negedge clk);
            #2;
            check1("release_memReq", {31'd0, memReq}, 32'd0);
            check1("release_busy", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        hold = 1'b0;
        @(posedge clk);
        #1;
        check1("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int c;
        checks = 0; failures = 0; cyc = 0; sync_count = 0;
        bp = 1'b0; stall_cnt = 0; prev_stall = 1'b0; prev_addr = '0; prev_wr = 1'b0;
        memAck = 1'b0;
        rst = 1'b1; hold = 1'b0; RowId = '0; cRowId = '0;
        victimValid = 1'b0; victimDirty = 1'b0; victimRowId = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check1("rst_memReq", {31'd0, memReq}, 32'd0);
        check1("rst_memWr", {31'd0, memWr}, 32'd0);
        check1("rst_memAddr", {12'd0, memAddr}, 32'd0);
        check1("rst_bufAddr", {24'd0, bufAddr}, 32'd0);
        check1("rst_bufWE", {31'd0, bufWE}, 32'd0);
        check1("rst_busy", {31'd0, busy}, 32'd0);
        check1("rst_sync", {31'd0, sync}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Clean fill: 150*8 = 1200, slot 3 -> buf 24
        do_req(17'd150, 5'd3, 1'b0, 1'b0, 17'd0, -1, 1200, 24, 9);
        // Dirty evict: 590*8 = 4720 written, then 1200 read
        do_req(17'd150, 5'd3, 1'b1, 1'b1, 17'd590, 4720, 1200, 24, 17);
        // Hit on victim: no traffic
        do_req(17'd590, 5'd3, 1'b1, 1'b1, 17'd590, -1, -1, 24, 1);
        // Backpressure: clean valid victim, 1000*8 = 8000, slot 31 -> 248; 4 cycles/beat
        bp = 1'b1;
        do_req(17'd1000, 5'd31, 1'b1, 1'b0, 17'd5, -1, 8000, 248, 33);
        bp = 1'b0;

        // Reset mid-FILL while beat 4 is presented
        for (int b = 0; b < 4; b++)
            exp_q.push_back('{1'b0, 20'(1200 + b), 8'(24 + b)});
        @(negedge clk);
        hold = 1'b1; RowId = 17'd150; cRowId = 5'd3;
        victimValid = 1'b0; victimDirty = 1'b0; victimRowId = 17'd0;
        @(posedge clk);
        #1;
        c = cyc;
        repeat (4) @(posedge clk);
        #1;
        check1("midfill_addr", {12'd0, memAddr}, 32'd1204);
        @(negedge clk);
        rst = 1'b1; hold = 1'b0;
        @(posedge clk);
        #1;
        check1("midrst_memReq", {31'd0, memReq}, 32'd0);
        check1("midrst_busy", {31'd0, busy}, 32'd0);
        check1("midrst_sync", {31'd0, sync}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        // New request after reset starts from beat 0: 590*8 = 4720, slot 7 -> 56
        do_req(17'd590, 5'd7, 1'b0, 1'b0, 17'd0, -1, 4720, 56, 9);

        repeat (3) @(negedge clk);
        check1("beats_left", exp_q.size(), 32'd0);
        check1("syncs_left", sync_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
